// File: rtl/gate_bist_pkg.sv
// Shared types and truth tables for the 2-input gate BIST.
// Truth-table bit index is {a,b}.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_top.sv
// Wrapper placing the gate under test beside its BIST controller.
// The gate is a 4-entry LUT so any 2-input function can be modelled.
module gate_bist_top
    import gate_bist_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] GATE_TT       = TT_XOR,
    parameter logic [3:0] EXPECTED      = TT_XOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result_mask,
    output logic [3:0] fail_mask
);

    logic w_a;
    logic w_b;
    logic w_c;

    assign w_c = GATE_TT[{w_a, w_b}];

    gate_bist_ctrl #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .EXPECTED      (EXPECTED)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .c           (w_c),
        .a           (w_a),
        .b           (w_b),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .result_mask (result_mask),
        .fail_mask   (fail_mask)
    );

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks {a,b} through 00..11, holds each
// vector SETTLE_CYCLES clocks, samples c and checks it.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = TT_XOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result_mask,
    output logic [3:0] fail_mask
);

    localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE_CYCLES - 1);

    state_t        r_state;
    logic [1:0]    r_vec;
    logic [CW-1:0] r_cnt;
    logic          r_a;
    logic          r_b;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [3:0]    r_result;
    logic [3:0]    r_fail;

    logic [3:0]    w_fail_next;
    logic [1:0]    w_vec_inc;

    // Fail mask including the sample taken this cycle, so pass sees it.
    always_comb begin
        w_fail_next        = r_fail;
        w_fail_next[r_vec] = c ^ EXPECTED[r_vec];
    end

    assign w_vec_inc = r_vec + 2'd1;

    // Sequencer FSM with settle counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_result <= '0;
            r_fail   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_a    <= 1'b0;
                    r_b    <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_vec    <= '0;
                        r_cnt    <= CNT_INIT;
                        r_result <= '0;
                        r_fail   <= '0;
                        r_pass   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_result[r_vec] <= c;
                        r_fail          <= w_fail_next;
                        if (r_vec == 2'd3) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_fail_next == 4'b0000);
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_vec <= w_vec_inc;
                            r_cnt <= CNT_INIT;
                            r_a   <= w_vec_inc[1];
                            r_b   <= w_vec_inc[0];
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign result_mask = r_result;
    assign fail_mask   = r_fail;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl with a done-result scoreboard.
// Two instances: S=2 and S=1, both expecting the XOR table.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    typedef struct {
        logic [3:0] rm;
        logic [3:0] fm;
        logic       p;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start2, start1;
    logic a2, b2, c2, busy2, done2, pass2;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [3:0] rm2, fm2, rm1, fm1;

    int mode2 = 0;
    int mode1 = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int t0;

    exp_t q2[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 0: xor, 1: stuck-at-0, other: and
    function automatic logic gf(int m, logic x, logic y);
        case (m)
            0: return x ^ y;
            1: return 1'b0;
            default: return x & y;
        endcase
    endfunction

    assign c2 = gf(mode2, a2, b2);
    assign c1 = gf(mode1, a1, b1);

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(TT_XOR)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .c(c2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .result_mask(rm2), .fail_mask(fm2)
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(TT_XOR)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .c(c1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .result_mask(rm1), .fail_mask(fm1)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exv);
        total++;
        assert (obs === exv) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exv, cyc);
        end
    endtask

    task automatic nc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push2(logic [3:0] rm, logic [3:0] fm, logic p, int dc);
        exp_t e;
        e.rm = rm; e.fm = fm; e.p = p; e.cyc = dc;
        q2.push_back(e);
    endtask

    task automatic push1(logic [3:0] rm, logic [3:0] fm, logic p, int dc);
        exp_t e;
        e.rm = rm; e.fm = fm; e.p = p; e.cyc = dc;
        q1.push_back(e);
    endtask

    // Scoreboard for the S=2 instance.
    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            total++;
            assert (q2.size() != 0) else begin
                bad++;
                $error("FAIL done2_unexpected obs=1 exp=0 cyc=%0d", cyc);
            end
            if (q2.size() != 0) begin
                exp_t e;
                e = q2.pop_front();
                chk("done2_cycle", cyc, e.cyc);
                chk("result2", {28'd0, rm2}, {28'd0, e.rm});
                chk("fail2", {28'd0, fm2}, {28'd0, e.fm});
                chk("pass2", {31'd0, pass2}, {31'd0, e.p});
                chk("busy2_at_done", {31'd0, busy2}, 32'd0);
            end
        end
    end

    // Scoreboard for the S=1 instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            total++;
            assert (q1.size() != 0) else begin
                bad++;
                $error("FAIL done1_unexpected obs=1 exp=0 cyc=%0d", cyc);
            end
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("done1_cycle", cyc, e.cyc);
                chk("result1", {28'd0, rm1}, {28'd0, e.rm});
                chk("fail1", {28'd0, fm1}, {28'd0, e.fm});
                chk("pass1", {31'd0, pass1}, {31'd0, e.p});
            end
        end
    end

    initial begin
        rst = 1'b1;
        start2 = 1'b0;
        start1 = 1'b0;
        nc(2);
        rst = 1'b0;
        nc(1);
        chk("reset_outs2", {21'd0, a2, b2, busy2, done2, pass2, rm2, fm2}, 32'd0);
        chk("reset_outs1", {21'd0, a1, b1, busy1, done1, pass1, rm1, fm1}, 32'd0);

        // XOR gate, S=2
        mode2 = 0;
        t0 = cyc;
        start2 = 1'b1;
        push2(4'b0110, 4'b0000, 1'b1, t0 + 9);
        nc(1);
        start2 = 1'b0;
        chk("vec0", {29'd0, a2, b2, busy2}, 32'b001);
        nc(1);
        chk("vec0_hold", {29'd0, a2, b2, busy2}, 32'b001);
        nc(1);
        chk("vec1", {29'd0, a2, b2, busy2}, 32'b011);
        nc(2);
        chk("vec2", {29'd0, a2, b2, busy2}, 32'b101);
        nc(2);
        chk("vec3", {29'd0, a2, b2, busy2}, 32'b111);
        nc(2);
        chk("ab_low_done", {30'd0, a2, b2}, 32'd0);
        nc(1);
        chk("done_one_cycle", {31'd0, done2}, 32'd0);
        chk("pass_hold", {27'd0, pass2, rm2}, {27'd0, 1'b1, 4'b0110});

        // c stuck at 0
        mode2 = 1;
        t0 = cyc;
        start2 = 1'b1;
        push2(4'b0000, 4'b0110, 1'b0, t0 + 9);
        nc(1);
        start2 = 1'b0;
        nc(10);

        // AND gate against XOR table, S=1
        mode1 = 2;
        t0 = cyc;
        start1 = 1'b1;
        push1(4'b1000, 4'b1110, 1'b0, t0 + 5);
        nc(1);
        start1 = 1'b0;
        chk("s1_vec0", {29'd0, a1, b1, busy1}, 32'b001);
        nc(1);
        chk("s1_vec1", {29'd0, a1, b1, busy1}, 32'b011);
        nc(6);

        // start pulses during SETTLE and DONE are ignored
        mode2 = 0;
        t0 = cyc;
        start2 = 1'b1;
        push2(4'b0110, 4'b0000, 1'b1, t0 + 9);
        nc(1);
        start2 = 1'b0;
        nc(2);
        start2 = 1'b1;
        nc(1);
        start2 = 1'b0;
        nc(5);
        start2 = 1'b1;
        nc(1);
        start2 = 1'b0;
        nc(3);
        chk("no_restart", {31'd0, busy2}, 32'd0);

        // start held high: back-to-back runs
        t0 = cyc;
        start2 = 1'b1;
        push2(4'b0110, 4'b0000, 1'b1, t0 + 9);
        nc(10);
        push2(4'b0110, 4'b0000, 1'b1, t0 + 19);
        nc(1);
        chk("run2_started", {29'd0, a2, b2, busy2}, 32'b001);
        start2 = 1'b0;
        nc(11);

        // reset for 2 cycles mid-run
        t0 = cyc;
        start2 = 1'b1;
        nc(1);
        start2 = 1'b0;
        nc(3);
        rst = 1'b1;
        nc(2);
        rst = 1'b0;
        chk("midrun_reset", {21'd0, a2, b2, busy2, done2, pass2, rm2, fm2}, 32'd0);
        nc(12);

        // reset in cycle 4, restart in cycle 6
        t0 = cyc;
        start2 = 1'b1;
        nc(1);
        start2 = 1'b0;
        nc(3);
        rst = 1'b1;
        nc(1);
        rst = 1'b0;
        chk("reset_c4", {24'd0, busy2, a2, b2, pass2, rm2}, 32'd0);
        nc(1);
        start2 = 1'b1;
        push2(4'b0110, 4'b0000, 1'b1, t0 + 15);
        nc(1);
        start2 = 1'b0;
        chk("restart_vec0", {29'd0, a2, b2, busy2}, 32'b001);
        nc(12);

        chk("q2_drained", q2.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Built-in self-test sequencer for one external 2-input logic gate (xor, and, or and similar).
- Drives the gate inputs a/b through all four vectors and waits a programmable settle time per vector.
- Samples gate output c, compares each sample against a parameterised truth table and reports pass/fail with a per-vector mismatch mask.
- Replaces hand-written stimulus benches with a clocked, reusable checker at the gate wrapper level.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before c is sampled; legal range >=1.
- EXPECTED, 4'b0110, expected c per vector; bit index = {a,b}; default is the XOR truth table.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a test run; sampled only in IDLE.
- c  in  1  output of gate under test.
- a  out  1  gate input a, registered.
- b  out  1  gate input b, registered.
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse when results are valid.
- pass  out  1  1 when fail_mask==0 at end of run; held until next start.
- result_mask  out  4  captured c per vector, index {a,b}.
- fail_mask  out  4  result_mask XOR EXPECTED.

Behaviour:
- Reset: one clock with rst=1 forces state IDLE and clears all outputs (a, b, busy, done, pass, result_mask, fail_mask) and internal vec/cnt to 0. rst has priority over start and any state. Reset mid-run aborts the run with no done pulse.
- States:
  - IDLE: a=b=0, busy=0, done=0. If start=1: vec<=0, cnt<=SETTLE_CYCLES-1, result_mask<=0, fail_mask<=0, pass<=0, go to SETTLE.
  - SETTLE: busy=1, {a,b}=vec. If cnt!=0, cnt<=cnt-1. If cnt==0, result_mask[vec]<=c and fail_mask[vec]<=c^EXPECTED[vec]; then:
    - vec==3: go to DONE.
    - otherwise: vec<=vec+1 and cnt<=SETTLE_CYCLES-1.
  - DONE: busy=0, done=1 for exactly one cycle, pass<=(final fail_mask==0), a=b=0, go to IDLE.
- Timing, with start seen high in cycle 0 and S=SETTLE_CYCLES:
  - Vector k is driven during cycles 1+k*S .. (k+1)*S.
  - c is sampled at the clock edge ending cycle (k+1)*S.
  - done and pass are valid in cycle 4S+1.
  - IDLE is re-entered in cycle 4S+2.
  - Minimum run-to-run period is 4S+2 cycles.
- start handling:
  - start in SETTLE or DONE is ignored, not queued.
  - start held high continuously produces back-to-back runs.
- Widths:
  - vec is 2 bits; no wrap past 3, because termination is checked before increment.
  - cnt is $clog2(SETTLE_CYCLES+1) bits.
- a, b, busy and done are registered, with no combinational path from inputs.
- pass, result_mask and fail_mask hold their values until the next accepted start or reset.

Decomposition:
- Package gate_bist_pkg:
  - State enum {IDLE, SETTLE, DONE}.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001.
- No internal sub-module; the settle counter is inline.
- The gate under test is instantiated beside the controller in a wrapper, gate_bist_top.

Test Plan:
1. Reset: rst=1 for 2 cycles during a run -> next cycle a=b=0, busy=0, done=0, pass=0, result_mask=0000, fail_mask=0000, and no done pulse afterwards.
2. XOR gate, S=2, start pulse in cycle 0 -> {a,b}=00/01/10/11 in cycles 1/3/5/7, done in cycle 9 only, result_mask=0110, fail_mask=0000, pass=1, busy low in cycle 9.
3. c tied to 0, EXPECTED=TT_XOR -> result_mask=0000, fail_mask=0110, pass=0.
4. AND gate with EXPECTED=TT_XOR, S=1 -> done in cycle 5, result_mask=1000, fail_mask=1110, pass=0.
5. start pulsed in cycles 3 and 9 of a run, S=2 -> no restart and one done pulse. start held high from cycle 0 -> runs begin in cycles 0 and 10, done in cycles 9 and 19.
6. rst in cycle 4 of a run, then start in cycle 6 -> first vector 00 in cycle 7, clean completion with done in cycle 15.
